// File: rtl/vga_timing_pkg.sv
// Timing constants and the pattern-select enum for the VGA RGB source.
package vga_timing_pkg;

    localparam int CW       = 10;   // width of h/v counters and positions

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Sync pulses sit right after the front porch; the end value is exclusive.
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int BAR_W    = H_ACTIVE / 8;

    typedef enum logic [1:0] {
        PAT_BLACK = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical/frame counters with unregistered sync and enable decode.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BACK   = vga_timing_pkg::H_BACK,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BACK   = vga_timing_pkg::V_BACK
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] h,
    output logic [CW-1:0] v,
    output logic [7:0]    frame,
    output logic          de_pre,
    output logic          hs_pre,
    output logic          vs_pre
);

    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);

    // Raster scan: h wraps into v, v wraps into the frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            h     <= '0;
            v     <= '0;
            frame <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
                v     <= '0;
                frame <= frame + 8'd1;
            end else begin
                v <= v + CW'(1);
            end
        end else begin
            h <= h + CW'(1);
        end
    end

    assign de_pre = (h < H_ACT) && (v < V_ACT);
    assign hs_pre = !((h >= HS_BEG) && (h < HS_END));
    assign vs_pre = !((v >= VS_BEG) && (v < VS_END));

endmodule

// File: rtl/vga_rgb_source.sv
// Pixel-rate test-pattern source: mode latch, bar counter, pattern mux and
// one output register stage so sync, enable, position and colour stay aligned.
module vga_rgb_source
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BACK   = vga_timing_pkg::H_BACK,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BACK   = vga_timing_pkg::V_BACK,
    parameter int BAR_W    = H_ACTIVE / 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic [7:0]    frame,
    output logic [7:0]    dr,
    output logic [7:0]    dg,
    output logic [7:0]    db
);

    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CW-1:0] BAR_END = CW'(BAR_W - 1);

    logic [CW-1:0] h, v;
    logic [7:0]    frame_cnt;
    logic          de_pre, hs_pre, vs_pre;
    logic          at_origin;
    pattern_e      mode_q, pat;
    logic [CW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic [7:0]    pix_r, pix_g, pix_b;

    vga_sync_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .h      (h),
        .v      (v),
        .frame  (frame_cnt),
        .de_pre (de_pre),
        .hs_pre (hs_pre),
        .vs_pre (vs_pre)
    );

    assign at_origin = (h == '0) && (v == '0);
    // The frame's first pixel already uses the freshly sampled mode.
    assign pat = at_origin ? pattern_e'(mode) : mode_q;

    // Mode is captured only at frame start so a frame is never torn.
    always_ff @(posedge clk) begin
        if (reset)          mode_q <= PAT_BLACK;
        else if (at_origin) mode_q <= pattern_e'(mode);
    end

    // Bar index tracks h/BAR_W without a divider; it restarts with each line.
    always_ff @(posedge clk) begin
        if (reset || h == H_LAST) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (bar_px == BAR_END) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_px  <= bar_px + CW'(1);
        end
    end

    // Pattern mux; blanking forces black whatever the mode.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (de_pre) begin
            case (pat)
                PAT_BARS: begin
                    pix_r = {8{bar_idx[2]}};
                    pix_g = {8{bar_idx[1]}};
                    pix_b = {8{bar_idx[0]}};
                end
                PAT_GRAD: begin
                    pix_r = h[7:0];
                    pix_g = v[7:0];
                    pix_b = frame_cnt;
                end
                PAT_CHECK: begin
                    pix_r = {8{h[5] ^ v[5]}};
                    pix_g = {8{h[5] ^ v[5]}};
                    pix_b = {8{h[5] ^ v[5]}};
                end
                default: ;
            endcase
        end
    end

    // Single output stage: every output moves on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            hpos  <= '0;
            vpos  <= '0;
            frame <= '0;
            dr    <= '0;
            dg    <= '0;
            db    <= '0;
        end else begin
            hsync <= hs_pre;
            vsync <= vs_pre;
            de    <= de_pre;
            hpos  <= h;
            vpos  <= v;
            frame <= frame_cnt;
            dr    <= pix_r;
            dg    <= pix_g;
            db    <= pix_b;
        end
    end

endmodule
